// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  // Width of a counter that indexes 0..steps-1; never narrower than one bit.
  function automatic int cnt_width(input int steps);
    return (steps < 2) ? 1 : $clog2(steps);
  endfunction

  // Most-negative two's-complement value of a w-bit word (w <= 64).
  function automatic logic [63:0] min_val(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int W = 16
) (
  input  logic [W:0] rem_in,
  input  logic       bit_in,
  input  logic [W:0] divisor,
  output logic [W:0] rem_out,
  output logic       q_bit
);

  logic [W+1:0] shifted;

  // Partial remainder is always below the divisor, so the difference fits back into W+1 bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = (W+1)'(q_bit ? (shifted - {1'b0, divisor}) : shifted);
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, BITS_PER_CYCLE quotient bits per cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_signed,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int N     = DIVIDEND_WIDTH;
  localparam int M     = DIVISOR_WIDTH;
  localparam int K     = BITS_PER_CYCLE;
  localparam int STEPS = N / K;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [N-1:0] MIN_N = N'(min_val(N));

  state_t state, nstate;

  // Operand/sign registers
  logic [N-1:0]  dvd_q;     // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [M:0]    dvs_mag;
  logic [M:0]    rem;
  logic [CW-1:0] cnt;
  logic          neg_q, dvd_neg, ovf_pend;

  // Accept-time operand decode
  logic [N:0]   dvd_ext;
  logic [M:0]   dvs_ext;
  logic [N-1:0] dvd_mag_c;
  logic [M:0]   dvs_mag_c;
  logic         dz_c, ovf_c;

  // Sign-extend by one bit so MIN negates to its true magnitude.
  always_comb begin
    dvd_ext   = {in_signed & dividend[N-1], dividend};
    dvs_ext   = {in_signed & divisor[M-1], divisor};
    dvd_mag_c = N'(dvd_ext[N] ? -dvd_ext : dvd_ext);
    dvs_mag_c = dvs_ext[M] ? -dvs_ext : dvs_ext;
    dz_c      = (divisor == '0);
    ovf_c     = in_signed && (dividend == MIN_N) && (divisor == '1);
  end

  // Chain of restoring steps resolving K quotient bits per CALC cycle.
  logic [K:0][M:0] rem_c;
  logic [K-1:0]    qb;

  assign rem_c[0] = rem;

  for (genvar j = 0; j < K; j++) begin : g_step
    div_step #(.W(M)) u_step (
      .rem_in  (rem_c[j]),
      .bit_in  (dvd_q[N-1-j]),
      .divisor (dvs_mag),
      .rem_out (rem_c[j+1]),
      .q_bit   (qb[K-1-j])
    );
  end

  assign in_ready = (state == IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Next-state logic; divide-by-zero bypasses the datapath entirely.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid) nstate = dz_c ? DONE : CALC;
      CALC:    if (cnt == CW'(STEPS - 1)) nstate = FIXUP;
      FIXUP:   nstate = DONE;
      DONE:    if (out_valid && out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, sign-correct and publish in FIXUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q       <= '0;
      dvs_mag     <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      dvd_neg     <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd_q       <= dvd_mag_c;
          dvs_mag     <= dvs_mag_c;
          rem         <= '0;
          cnt         <= '0;
          neg_q       <= in_signed & (dividend[N-1] ^ divisor[M-1]);
          dvd_neg     <= in_signed & dividend[N-1];
          ovf_pend    <= ovf_c;
          div_by_zero <= dz_c;
          overflow    <= 1'b0;
          if (dz_c) begin
            quotient  <= '1;
            remainder <= dividend[M-1:0];
          end
        end
        CALC: begin
          rem   <= rem_c[K];
          dvd_q <= (dvd_q << K) | N'(qb);
          cnt   <= cnt + 1'b1;
        end
        FIXUP: begin
          // MIN/-1 falls out naturally: magnitude 2^(N-1) negated wraps back to MIN.
          quotient  <= neg_q ? -dvd_q : dvd_q;
          remainder <= dvd_neg ? -rem[M-1:0] : rem[M-1:0];
          overflow  <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // out_valid rises the cycle after DONE is entered and drops on the handshake edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       out_valid <= 1'b0;
    else if (out_valid && out_ready) out_valid <= 1'b0;
    else if (state == DONE)          out_valid <= 1'b1;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Random + directed bench driving three dividers (1, 2, 4 bits/cycle) in lockstep.
module tb_seq_divider;

  localparam int N  = 32;
  localparam int M  = 16;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_signed, out_ready;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic [ND-1:0] in_ready, out_valid, div_by_zero, overflow;
  logic [ND-1:0][N-1:0] quotient;
  logic [ND-1:0][M-1:0] remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    seq_divider #(
      .DIVIDEND_WIDTH (N),
      .DIVISOR_WIDTH  (M),
      .BITS_PER_CYCLE (1 << g)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready[g]),
      .in_signed   (in_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready),
      .quotient    (quotient[g]),
      .remainder   (remainder[g]),
      .div_by_zero (div_by_zero[g]),
      .overflow    (overflow[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division semantics plus the two flagged special cases.
  task automatic ref_div(input logic s, input logic [N-1:0] a, input logic [M-1:0] b,
                         output logic [N-1:0] q, output logic [M-1:0] r,
                         output logic dz, output logic ov);
    longint sa, sb, sq, sr;
    dz = 1'b0;
    ov = 1'b0;
    if (b == '0) begin
      dz = 1'b1;
      q  = '1;
      r  = a[M-1:0];
    end else if (s && a == 32'h8000_0000 && b == 16'hFFFF) begin
      ov = 1'b1;
      q  = 32'h8000_0000;
      r  = '0;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({48'd0, b});
      end
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[N-1:0];
      r  = sr[M-1:0];
    end
  endtask

  // One operation on all three DUTs; hold>0 keeps out_ready low that many extra cycles.
  task automatic do_op(input logic s, input logic [N-1:0] a, input logic [M-1:0] b, input int hold);
    logic [N-1:0] eq;
    logic [M-1:0] er;
    logic edz, eov;
    int lat [ND];
    int cyc;
    bit all_seen;
    ref_div(s, a, b, eq, er, edz, eov);
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'({ND{1'b1}}));
    in_valid  = 1'b1;
    in_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = 16'($urandom);
    in_signed = 1'($urandom);
    chk("busy_in_ready", 64'(in_ready), 64'(0));
    for (int g = 0; g < ND; g++) lat[g] = -1;
    cyc = 0;
    all_seen = 1'b0;
    while (!all_seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      all_seen = 1'b1;
      for (int g = 0; g < ND; g++) begin
        if (out_valid[g] && lat[g] < 0) lat[g] = cyc;
        if (lat[g] < 0) all_seen = 1'b0;
      end
    end
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("latency_k%0d", 1 << g), 64'(lat[g]), 64'(edz ? 1 : N / (1 << g) + 2));
      chk($sformatf("quotient_k%0d", 1 << g), 64'(quotient[g]), 64'(eq));
      chk($sformatf("remainder_k%0d", 1 << g), 64'(remainder[g]), 64'(er));
      chk($sformatf("div_by_zero_k%0d", 1 << g), 64'(div_by_zero[g]), 64'(edz));
      chk($sformatf("overflow_k%0d", 1 << g), 64'(overflow[g]), 64'(eov));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = 16'($urandom);
      @(posedge clk);
      #1;
      chk("hold_out_valid", 64'(out_valid), 64'({ND{1'b1}}));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      for (int g = 0; g < ND; g++) begin
        chk($sformatf("hold_q_k%0d", 1 << g), 64'(quotient[g]), 64'(eq));
        chk($sformatf("hold_r_k%0d", 1 << g), 64'(remainder[g]), 64'(er));
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", 64'(out_valid), 64'(0));
    chk("post_hs_in_ready", 64'(in_ready), 64'({ND{1'b1}}));
  endtask

  initial begin
    int cyc;
    bit saw_valid;
    logic s;
    logic [N-1:0] a;
    logic [M-1:0] b;
    int sel;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_quotient", 64'(quotient[0]), 64'(0));
    chk("rst_remainder", 64'(remainder[2]), 64'(0));
    chk("rst_flags", 64'({div_by_zero, overflow}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'({ND{1'b1}}));

    // Directed cases
    do_op(1'b0, 32'd100, 16'd7, 0);
    do_op(1'b1, 32'hFFFF_FF9C, 16'd7, 0);          // -100 / 7
    do_op(1'b1, 32'd100, 16'hFFF9, 0);             // 100 / -7
    do_op(1'b0, 32'd5, 16'd0, 0);
    do_op(1'b1, 32'h8000_0000, 16'hFFFF, 0);
    do_op(1'b0, 32'h8000_0000, 16'hFFFF, 0);       // same bits, unsigned: no overflow
    do_op(1'b1, 32'h8000_0000, 16'h8000, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 16'hFFFF, 0);
    do_op(1'b0, 32'd12345, 16'd77, 6);

    // Reset during CALC must abort without ever presenting a result.
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = 1'b0;
    dividend  = 32'd999;
    divisor   = 16'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid != '0) saw_valid = 1'b1;
    end
    chk("midrst_no_result", 64'(saw_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'({ND{1'b1}}));
    do_op(1'b1, 32'hFFFF_FC19, 16'd3, 0);          // -999 / 3

    // Randomized, biased toward the corner cases
    for (int i = 0; i < 2000; i++) begin
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      a   = $urandom;
      b   = 16'($urandom);
      case (sel)
        0:       b = '0;
        1:       begin a = 32'h8000_0000; b = 16'hFFFF; end
        2:       b = 16'($urandom_range(1, 15));
        3:       a = 32'($urandom_range(0, 255));
        4:       b = 16'h8000;
        default: ;
      endcase
      do_op(s, a, b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
